ecs3_serial_rx: RTL and testbench

Serial frame receiver that consumes the bit stream produced by the ECS3 transmitter running on the divided clock `clkTX`. It runs on the undivided clock (`clkRX` = `clk`), oversamples the line at `OVS` system clocks per bit, and recovers framed data words. Each recovered word is presented through a valid/ack holding register to the downstream logic.

---
 rtl/ecs3_serial_rx.sv | 133 +++++++++++++
 tb/tb_ecs3_serial_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ecs3_serial_rx.sv
// ecs3_serial_rx: oversampling frame receiver for the ECS3 serial link.
// Mid-bit sampling, valid/ack holding register, framing and overrun pulses.
module ecs3_serial_rx #(
  parameter int DATA_W = 8,
  parameter int OVS    = 4
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              rx_in,
  input  logic              rx_ack,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] HALF_T = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(OVS - 1);
  localparam logic [BW-1:0] LAST_B = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic              syncA;
  logic              rxS;
  logic [TW-1:0]     tick;
  logic [BW-1:0]     bitCnt;
  logic [DATA_W-1:0] shreg;
  logic              sample;
  logic              goodFrame;
  logic              badFrame;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      syncA <= 1'b1;
      rxS   <= 1'b1;
    end else begin
      syncA <= rx_in;
      rxS   <= syncA;
    end
  end

  always_comb begin
    stateNext = state;
    sample    = 1'b0;
    goodFrame = 1'b0;
    badFrame  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxS) stateNext = START;
      end
      START: begin
        if (tick == HALF_T) begin
          sample    = 1'b1;
          stateNext = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick == LAST_T) begin
          sample = 1'b1;
          if (bitCnt == LAST_B) stateNext = STOP;
        end
      end
      STOP: begin
        if (tick == LAST_T) begin
          sample    = 1'b1;
          goodFrame = rxS;
          badFrame  = !rxS;
          stateNext = rxS ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxS) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= stateNext;
      busy  <= (state != IDLE);
    end
  end

  // Tick restarts at each sample so every bit spans exactly OVS clocks.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      tick   <= '0;
      bitCnt <= '0;
      shreg  <= '0;
    end else begin
      if (state == IDLE || sample) tick <= '0;
      else                         tick <= tick + 1'b1;
      if (state == START)
        bitCnt <= '0;
      else if (state == DATA && sample)
        bitCnt <= bitCnt + 1'b1;
      if (state == DATA && sample)
        shreg <= {rxS, shreg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= badFrame;
      overrun   <= goodFrame & rx_valid & ~rx_ack;
      if (goodFrame) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ecs3_serial_rx.sv
// tb_ecs3_serial_rx: directed bench with a word scoreboard.
// Expected words carry their required completion cycle and overrun flag.
module tb_ecs3_serial_rx;
  localparam int DW    = 8;
  localparam int OVS   = 4;
  localparam int FRAME = OVS * (DW + 2);

  logic          clk = 1'b0;
  logic          nRST;
  logic          rx_in;
  logic          manualAck;
  logic          autoAck;
  logic          rxAck;
  logic [DW-1:0] rxData;
  logic          rxValid;
  logic          frameErr;
  logic          overrun;
  logic          busy;

  assign rxAck = manualAck | (autoAck & rxValid);

  ecs3_serial_rx #(.DATA_W(DW), .OVS(OVS)) dut (
    .clk      (clk),
    .nRST     (nRST),
    .rx_in    (rx_in),
    .rx_ack   (rxAck),
    .rx_data  (rxData),
    .rx_valid (rxValid),
    .frame_err(frameErr),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            at;
    logic          ovr;
  } exp_t;

  exp_t sb[$];

  int            checks  = 0;
  int            errors  = 0;
  int            feCount = 0;
  int            ovCount = 0;
  int            feCycle = -1;
  logic          prevValid = 1'b0;
  logic          prevFe    = 1'b0;
  logic          prevOv    = 1'b0;
  logic [DW-1:0] prevData  = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (rxValid && (!prevValid || rxData !== prevData)) begin
      chk("word_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("word_data", 32'(rxData), 32'(e.d));
        chk("word_cycle", cyc, e.at);
        chk("word_overrun", 32'(overrun), 32'(e.ovr));
      end
    end
    if (frameErr) begin
      feCount++;
      feCycle = cyc;
      chk("frame_err_width", 32'(prevFe), 0);
    end
    if (overrun) begin
      ovCount++;
      chk("overrun_width", 32'(prevOv), 0);
    end
    prevValid = rxValid;
    prevData  = rxData;
    prevFe    = frameErr;
    prevOv    = overrun;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic sendFrame(input logic [DW-1:0] d, input logic stopBit);
    logic [DW+1:0] f;
    f = {stopBit, d, 1'b0};
    for (int i = 0; i < DW + 2; i++) begin
      rx_in = f[i];
      repeat (OVS) tick();
    end
  endtask

  task automatic sendGood(input logic [DW-1:0] d, input logic ovr);
    sb.push_back('{d, cyc + 1 + FRAME, ovr});
    sendFrame(d, 1'b1);
  endtask

  task automatic ackPulse();
    manualAck = 1'b1;
    tick();
    manualAck = 1'b0;
  endtask

  initial begin
    int            n;
    int            fe0;
    int            ov0;
    logic [DW-1:0] rd;

    nRST      = 1'b0;
    rx_in     = 1'b1;
    manualAck = 1'b0;
    autoAck   = 1'b0;
    repeat (3) tick();
    chk("rst_data", 32'(rxData), 0);
    chk("rst_valid", 32'(rxValid), 0);
    chk("rst_frame_err", 32'(frameErr), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    nRST = 1'b1;
    repeat (4) tick();

    sendGood(8'hA5, 1'b0);
    tick();
    chk("good_frame_err", feCount, 0);
    repeat (3) tick();
    chk("good_valid_held", 32'(rxValid), 1);
    ackPulse();
    chk("good_valid_cleared", 32'(rxValid), 0);

    fe0   = feCount;
    n     = cyc;
    rx_in = 1'b0;
    tick();
    rx_in = 1'b1;
    repeat (3) tick();
    chk("false_busy_hi", 32'(busy), 1);
    chk("false_busy_cycle", cyc, n + 4);
    repeat (2) tick();
    chk("false_busy_lo", 32'(busy), 0);
    repeat (4) tick();
    chk("false_no_fe", feCount, fe0);
    chk("false_no_valid", 32'(rxValid), 0);

    fe0 = feCount;
    n   = cyc;
    sendFrame(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (20) tick();
    chk("ferr_count", feCount - fe0, 1);
    chk("ferr_cycle", feCycle, n + 1 + FRAME);
    chk("ferr_data_kept", 32'(rxData), 32'h A5);
    chk("ferr_valid_kept", 32'(rxValid), 0);
    chk("ferr_busy_held", 32'(busy), 1);
    rx_in = 1'b1;
    repeat (6) tick();
    chk("ferr_busy_released", 32'(busy), 0);
    sendGood(8'h81, 1'b0);
    repeat (2) tick();
    chk("after_ferr_valid", 32'(rxValid), 1);
    ackPulse();

    ov0 = ovCount;
    sendGood(8'h11, 1'b0);
    sendGood(8'h22, 1'b1);
    repeat (2) tick();
    chk("ovr_count", ovCount - ov0, 1);
    chk("ovr_data", 32'(rxData), 32'h22);
    chk("ovr_valid", 32'(rxValid), 1);
    ackPulse();

    ov0 = ovCount;
    sendGood(8'h11, 1'b0);
    sendGood(8'h22, 1'b0);
    manualAck = 1'b1;
    tick();
    manualAck = 1'b0;
    chk("simack_valid", 32'(rxValid), 1);
    chk("simack_data", 32'(rxData), 32'h22);
    tick();
    chk("simack_no_ovr", ovCount - ov0, 0);
    ackPulse();
    chk("simack_cleared", 32'(rxValid), 0);

    rx_in = 1'b0;
    repeat (OVS) tick();
    rx_in = 1'b1;
    repeat (4 * OVS + 2) tick();
    nRST = 1'b0;
    #1;
    chk("midrst_data", 32'(rxData), 0);
    chk("midrst_valid", 32'(rxValid), 0);
    chk("midrst_frame_err", 32'(frameErr), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    chk("midrst_busy", 32'(busy), 0);
    repeat (3) tick();
    nRST = 1'b1;
    repeat (4) tick();
    sendGood(8'h5A, 1'b0);
    repeat (2) tick();
    ackPulse();

    fe0     = feCount;
    ov0     = ovCount;
    autoAck = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd = 8'($urandom_range(0, 255));
      sendGood(rd, 1'b0);
    end
    repeat (4) tick();
    autoAck = 1'b0;
    chk("stream_no_fe", feCount - fe0, 0);
    chk("stream_no_ovr", ovCount - ov0, 0);

    repeat (4) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
